// File: rtl/shift_reg_universal_if.sv
// rtl/shift_reg_universal_if.sv - control and data bundle for the universal shift register
interface shift_reg_universal_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH);

    logic             en;
    logic [1:0]       mode;
    logic             si;
    logic [WIDTH-1:0] pi;
    logic [WIDTH-1:0] po;
    logic             so;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic [CW-1:0]    bit_cnt;

    modport master (
        output en, mode, si, pi,
        input  po, so, word_out, word_valid, bit_cnt
    );

    modport slave (
        input  en, mode, si, pi,
        output po, so, word_out, word_valid, bit_cnt
    );
endinterface

// File: rtl/shift_reg_universal.sv
// rtl/shift_reg_universal.sv - universal shift register with hold/shl/shr/load and word strobe
module shift_reg_universal #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_reg_universal_if.slave bus
);
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic [CW-1:0]    cnt;

    logic             is_shift;
    logic [WIDTH-1:0] shift_q;

    // SHL and SHR share the counter and completion logic; only the new q differs.
    always_comb begin
        is_shift = (bus.mode == MODE_SHL) || (bus.mode == MODE_SHR);
        if (bus.mode == MODE_SHR) begin
            shift_q = {bus.si, q[WIDTH-1:1]};
        end else begin
            shift_q = {q[WIDTH-2:0], bus.si};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q       <= RESET_VAL;
            word_q  <= '0;
            valid_q <= 1'b0;
            cnt     <= '0;
        end else begin
            valid_q <= 1'b0;
            if (bus.en) begin
                if (is_shift) begin
                    q <= shift_q;
                    if (cnt == LAST_BIT) begin
                        cnt     <= '0;
                        word_q  <= shift_q;
                        valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end else if (bus.mode == MODE_LOAD) begin
                    q   <= bus.pi;
                    cnt <= '0;
                end
            end
        end
    end

    // so previews the bit the next shift in the selected direction pushes out.
    assign bus.so         = (bus.mode == MODE_SHR) ? q[0] : q[WIDTH-1];
    assign bus.po         = q;
    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign bus.bit_cnt    = cnt;

    logic unused_hold;
    assign unused_hold = (MODE_HOLD == 2'b00);
endmodule

// File: tb/tb_shift_reg_universal.sv
// tb/tb_shift_reg_universal.sv - randomized self-checking bench for shift_reg_universal
module tb_shift_reg_universal;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_reg_universal_if #(.WIDTH(4)) b4 ();
    shift_reg_universal_if #(.WIDTH(5)) b5 ();

    shift_reg_universal #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    shift_reg_universal #(.WIDTH(5)) dut5 (.clk(clk), .reset(reset), .bus(b5));

    int tests = 0;
    int fails = 0;

    // reference model of the WIDTH=4 instance
    int m_q, m_cnt, m_wo;
    bit m_wv;

    task automatic set4(input bit en, input int mode, input bit si, input int pi);
        b4.en   = en;
        b4.mode = 2'(mode);
        b4.si   = si;
        b4.pi   = 4'(pi);
    endtask

    task automatic tick4();
        bit shifted;
        @(posedge clk);
        shifted = 0;
        if (!reset) begin
            m_q = 0; m_cnt = 0; m_wo = 0; m_wv = 0;
        end else begin
            m_wv = 0;
            if (b4.en) begin
                case (int'(b4.mode))
                    1: begin m_q = ((m_q * 2) + int'(b4.si)) % 16; shifted = 1; end
                    2: begin m_q = (m_q / 2) + 8 * int'(b4.si); shifted = 1; end
                    3: begin m_q = int'(b4.pi); m_cnt = 0; end
                    default: ;
                endcase
                if (shifted) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 4) begin
                        m_cnt = 0; m_wo = m_q; m_wv = 1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        set4(1, 1, 1, 0);
        reset = 1'b0;
        tick4();
        tests++;
        if (b4.po !== 4'b0000 || b4.bit_cnt !== 2'd0 || b4.word_valid !== 1'b0 || b4.word_out !== 4'b0000) begin
            fails++;
            $display("FAIL reset: po=%b cnt=%0d wv=%b wo=%b required 0000/0/0/0",
                     b4.po, b4.bit_cnt, b4.word_valid, b4.word_out);
        end
        reset = 1'b1;
    endtask

    task automatic test_shl();
        logic [3:0] sib;
        int         exp_q[4];
        sib = 4'b1101;
        exp_q = '{1, 2, 5, 11};
        for (int i = 0; i < 4; i++) begin
            set4(1, 1, sib[i], 0);
            tick4();
            tests++;
            if (b4.po !== 4'(exp_q[i]) || b4.word_valid !== (i == 3)) begin
                fails++;
                $display("FAIL shl[%0d]: po=%b wv=%b required %b/%b", i, b4.po, b4.word_valid,
                         4'(exp_q[i]), (i == 3));
            end
        end
        tests++;
        if (b4.word_out !== 4'b1011 || b4.bit_cnt !== 2'd0) begin
            fails++;
            $display("FAIL shl_word: wo=%b cnt=%0d required 1011/0", b4.word_out, b4.bit_cnt);
        end
    endtask

    task automatic test_shr();
        int exp_so[4];
        int strobes;
        exp_so = '{1, 0, 0, 1};
        strobes = 0;
        set4(1, 3, 0, 9);
        tick4();
        for (int i = 0; i < 4; i++) begin
            set4(1, 2, 0, 0);
            #1;
            tests++;
            if (b4.so !== 1'(exp_so[i])) begin
                fails++;
                $display("FAIL shr_so[%0d]: so=%b required %0d", i, b4.so, exp_so[i]);
            end
            tick4();
            if (b4.word_valid === 1'b1) strobes++;
        end
        tests++;
        if (b4.po !== 4'b0000 || strobes != 1 || b4.word_valid !== 1'b1 || b4.word_out !== 4'b0000) begin
            fails++;
            $display("FAIL shr_end: po=%b strobes=%0d wv=%b wo=%b required 0000/1/1/0000",
                     b4.po, strobes, b4.word_valid, b4.word_out);
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 7; i++) begin
            if (i >= 2 && i < 5) set4(0, 1, 1, 0);
            else                 set4(1, 1, i[0], 0);
            tick4();
            tests++;
            if (b4.po !== 4'(m_q) || b4.bit_cnt !== 2'(m_cnt) || b4.word_out !== 4'(m_wo)
                || b4.word_valid !== (i == 6)) begin
                fails++;
                $display("FAIL enable[%0d]: po=%b cnt=%0d wo=%b wv=%b required %b/%0d/%b/%b", i,
                         b4.po, b4.bit_cnt, b4.word_out, b4.word_valid, 4'(m_q), m_cnt, 4'(m_wo), (i == 6));
            end
        end
    endtask

    task automatic test_load_abort();
        for (int i = 0; i < 3; i++) begin set4(1, 1, 1, 0); tick4(); end
        set4(1, 3, 0, 6);
        tick4();
        tests++;
        if (b4.po !== 4'b0110 || b4.bit_cnt !== 2'd0 || b4.word_valid !== 1'b0) begin
            fails++;
            $display("FAIL load_abort: po=%b cnt=%0d wv=%b required 0110/0/0", b4.po, b4.bit_cnt, b4.word_valid);
        end
        for (int i = 0; i < 3; i++) begin set4(1, 1, 1, 0); tick4(); end
        reset = 1'b0;
        tick4();
        reset = 1'b1;
        tests++;
        if (b4.po !== 4'b0000 || b4.bit_cnt !== 2'd0 || b4.word_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: po=%b cnt=%0d wv=%b required 0000/0/0", b4.po, b4.bit_cnt, b4.word_valid);
        end
    endtask

    task automatic test_back_to_back();
        int last_strobe, gaps_bad, strobes;
        last_strobe = -1; gaps_bad = 0; strobes = 0;
        set4(1, 3, 0, 0);
        tick4();
        for (int i = 0; i < 12; i++) begin
            set4(1, int'($urandom_range(1, 2)), 1'($urandom), 0);
            tick4();
            if (b4.word_valid === 1'b1) begin
                if (last_strobe >= 0 && i - last_strobe != 4) gaps_bad++;
                last_strobe = i;
                strobes++;
            end
        end
        tests++;
        if (strobes != 3 || gaps_bad != 0 || b4.word_out !== 4'(m_wo)) begin
            fails++;
            $display("FAIL back_to_back: strobes=%0d bad_gaps=%0d wo=%b required 3/0/%b",
                     strobes, gaps_bad, b4.word_out, 4'(m_wo));
        end
    endtask

    task automatic test_random();
        int errs;
        bit exp_so;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) != 0);
            set4(($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)), 1'($urandom),
                 int'($urandom_range(0, 15)));
            #1;
            exp_so = (b4.mode == 2'b10) ? 1'(m_q % 2) : 1'(m_q / 8);
            if (b4.so !== exp_so) errs++;
            tick4();
            if (b4.po !== 4'(m_q) || b4.bit_cnt !== 2'(m_cnt) || b4.word_out !== 4'(m_wo)
                || b4.word_valid !== m_wv) begin
                errs++;
                if (errs < 5)
                    $display("FAIL random[%0d]: po=%b cnt=%0d wo=%b wv=%b required %b/%0d/%b/%b", i,
                             b4.po, b4.bit_cnt, b4.word_out, b4.word_valid, 4'(m_q), m_cnt, 4'(m_wo), m_wv);
            end
        end
        reset = 1'b1;
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL random_total: errors=%0d required 0", errs);
        end
    endtask

    task automatic test_width5();
        logic [4:0] pat;
        int         bits[12];
        int         exp_w;
        pat = 5'b11001;
        b4.en = 1'b0;
        b5.en = 1'b0;
        reset = 1'b0;
        tick4();
        reset = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            bits[n-1] = int'(pat[(n-1) % 5]);
            b5.en = 1'b1; b5.mode = 2'b01; b5.si = 1'(bits[n-1]);
            tick4();
            tests++;
            if (n % 5 == 0) begin
                exp_w = 0;
                for (int j = n - 5; j < n; j++) exp_w = exp_w * 2 + bits[j];
                if (b5.word_valid !== 1'b1 || b5.word_out !== 5'(exp_w)) begin
                    fails++;
                    $display("FAIL w5_strobe[%0d]: wv=%b wo=%b required 1/%b", n, b5.word_valid,
                             b5.word_out, 5'(exp_w));
                end
            end else if (b5.word_valid !== 1'b0) begin
                fails++;
                $display("FAIL w5_nostrobe[%0d]: wv=%b required 0", n, b5.word_valid);
            end
        end
        exp_w = 0;
        for (int j = 7; j < 12; j++) exp_w = exp_w * 2 + bits[j];
        tests++;
        if (b5.bit_cnt !== 3'd2 || b5.po !== 5'(exp_w)) begin
            fails++;
            $display("FAIL w5_end: cnt=%0d po=%b required 2/%b", b5.bit_cnt, b5.po, 5'(exp_w));
        end
        b5.en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set4(0, 0, 0, 0);
        b5.en = 1'b0; b5.mode = 2'b00; b5.si = 1'b0; b5.pi = '0;
        #1;
        test_reset();
        test_shl();
        test_shr();
        test_enable();
        test_load_abort();
        test_back_to_back();
        test_random();
        test_width5();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
